// File: rtl/tetris_pkg.sv
// tetris_pkg: shared LED matrix types, dimensions and scan states.
package tetris_pkg;
  localparam int MAT_DIM = 8;
  typedef logic [MAT_DIM-1:0][MAT_DIM-1:0] led_matrix_t;
  typedef logic [2:0] row_idx_t;
  typedef enum logic {BLANK, DRIVE} scanState_t;
endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: bitmap inputs and row/column drive outputs of the matrix scanner.
interface led_matrix_scanner_if;
  import tetris_pkg::*;
  led_matrix_t green_in;
  led_matrix_t red_in;
  logic [MAT_DIM-1:0] row_sel;
  logic [MAT_DIM-1:0] green_col_n;
  logic [MAT_DIM-1:0] red_col_n;
  logic frame_start;
  modport master(output green_in, red_in, input row_sel, green_col_n, red_col_n, frame_start);
  modport slave(input green_in, red_in, output row_sel, green_col_n, red_col_n, frame_start);
endinterface

// File: rtl/led_matrix_scanner_scan_timer.sv
// scan_timer: tick/row counters, BLANK/DRIVE state and frame strobes for the row scanner.
module scan_timer import tetris_pkg::*; #(
  parameter int TICKS_PER_ROW = 1000,
  parameter int BLANK_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  output row_idx_t   row,
  output scanState_t state,
  output logic       frameFirst,
  output logic       frameWrap
);
  localparam int TW = $clog2(TICKS_PER_ROW);
  localparam scanState_t RESET_STATE = (BLANK_TICKS > 0) ? BLANK : DRIVE;
  logic [TW-1:0] tick, nextTick;
  row_idx_t nextRow;
  scanState_t nextState;
  logic rowWrap;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tick <= '0;
      row <= '0;
      state <= RESET_STATE;
    end else begin
      tick <= nextTick;
      row <= nextRow;
      state <= nextState;
    end
  // state is registered from the next tick so it always matches the current tick
  always_comb begin
    rowWrap = tick == TW'(TICKS_PER_ROW - 1);
    frameWrap = rowWrap && row == row_idx_t'(MAT_DIM - 1);
    frameFirst = tick == '0 && row == '0;
    nextTick = rowWrap ? '0 : tick + 1'b1;
    nextRow = rowWrap ? row + 1'b1 : row;
    nextState = int'(nextTick) < BLANK_TICKS ? BLANK : DRIVE;
  end
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexes green/red 8x8 bitmaps onto a bicolour LED matrix.
// Define FRAME_LATCH_EN to display per-frame snapshots instead of live bitmaps.
module led_matrix_scanner import tetris_pkg::*; #(
  parameter int TICKS_PER_ROW = 1000,
  parameter int BLANK_TICKS = 16
) (
  input logic clk,
  input logic reset,
  led_matrix_scanner_if.slave bus
);
  if (TICKS_PER_ROW < 2) begin : gBadTicks
    $error("TICKS_PER_ROW must be at least 2");
  end
  if (BLANK_TICKS < 0 || BLANK_TICKS >= TICKS_PER_ROW) begin : gBadBlank
    $error("BLANK_TICKS must be in 0..TICKS_PER_ROW-1");
  end
  row_idx_t row;
  scanState_t state;
  logic frameFirst, frameWrap;
  led_matrix_t g, r;
  scan_timer #(.TICKS_PER_ROW(TICKS_PER_ROW), .BLANK_TICKS(BLANK_TICKS)) uTimer (
    .clk(clk),
    .reset(reset),
    .row(row),
    .state(state),
    .frameFirst(frameFirst),
    .frameWrap(frameWrap)
  );
`ifdef FRAME_LATCH_EN
  // snapshot on the last cycle of row 7 so the next frame is coherent
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      g <= '0;
      r <= '0;
    end else if (frameWrap) begin
      g <= bus.green_in;
      r <= bus.red_in;
    end
`else
  logic unusedFrameWrap;
  assign unusedFrameWrap = frameWrap;
  assign g = bus.green_in;
  assign r = bus.red_in;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.row_sel <= '0;
      bus.green_col_n <= '1;
      bus.red_col_n <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.row_sel <= state == DRIVE ? (MAT_DIM'(1) << row) : '0;
      bus.green_col_n <= state == DRIVE ? ~g[row] : '1;
      bus.red_col_n <= state == DRIVE ? ~r[row] : '1;
      bus.frame_start <= frameFirst;
    end
endmodule
